// File: rtl/shop_purchase_ctrl.sv
//-----------------------------------------------------------------------------
// shop_purchase_ctrl
//
// Purchase sequencer between a debounced buy button and a wallet. A buy
// request in IDLE captures the price (base item cost scaled by wallet level),
// issues a single-cycle purchase strobe, then waits up to 8 cycles for the
// wallet to confirm. The result is kept in sticky lastOk/lastFail flags, and
// successful purchases are counted (saturating at 255).
//
// Build option:
//   SHOP_COOLDOWN_EN  defined   -> 16-cycle COOL state after every WAIT exit
//                     undefined -> WAIT returns straight to IDLE
//
// Ports:
//   Clk          in   system clock, rising edge
//   Reset        in   synchronous, active-high reset
//   buyBtn       in   single-cycle buy request (ignored while busy)
//   itemSel      in   [1:0] item index, sampled when buyBtn is accepted
//   walletLevel  in   [1:0] wallet level, sampled with itemSel
//   purchase     out  one-cycle purchase strobe (ISSUE state only)
//   unitCost     out  [11:0] price shown to the wallet, stable ISSUE..WAIT
//   buySucc      in   wallet success pulse, honoured only in WAIT
//   busy         out  high in every state except IDLE
//   lastOk       out  sticky: most recent transaction succeeded
//   lastFail     out  sticky: most recent transaction timed out
//   buyCount     out  [7:0] successful purchases, saturating
//-----------------------------------------------------------------------------
module shop_purchase_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        buyBtn,
  input  logic [1:0]  itemSel,
  input  logic [1:0]  walletLevel,
  output logic        purchase,
  output logic [11:0] unitCost,
  input  logic        buySucc,
  output logic        busy,
  output logic        lastOk,
  output logic        lastFail,
  output logic [7:0]  buyCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    COOL  = 2'd3
  } state_t;

`ifdef SHOP_COOLDOWN_EN
  localparam state_t WAIT_EXIT = COOL;
`else
  localparam state_t WAIT_EXIT = IDLE;
`endif

  state_t      state;
  state_t      next_state;
  logic [2:0]  wait_cnt;      // WAIT cycles elapsed, 0 on the first WAIT cycle
  logic        accept;        // buy request taken this cycle
  logic        succ_evt;      // wallet confirmed inside the WAIT window
  logic        tmo_evt;       // 8th WAIT cycle passed without confirmation
  logic [6:0]  base_cost;
  logic [2:0]  level_mult;
  logic [11:0] new_cost;
`ifdef SHOP_COOLDOWN_EN
  logic [3:0]  cool_cnt;      // COOL cycles elapsed, 0 on the first COOL cycle
`endif

  // Price of the request currently on the inputs.
  always_comb begin
    base_cost = 7'd10;
    case (itemSel)
      2'd0:    base_cost = 7'd10;
      2'd1:    base_cost = 7'd25;
      2'd2:    base_cost = 7'd50;
      default: base_cost = 7'd100;
    endcase
  end

  assign level_mult = {1'b0, walletLevel} + 3'd1;
  assign new_cost   = 12'(base_cost) * 12'(level_mult);  // max 100*4 = 400

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    purchase   = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    succ_evt   = 1'b0;
    tmo_evt    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (buyBtn) begin
          accept     = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        purchase   = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        // Success wins over a timeout landing in the same cycle.
        if (buySucc) begin
          succ_evt   = 1'b1;
          next_state = WAIT_EXIT;
        end else if (wait_cnt == 3'd7) begin
          tmo_evt    = 1'b1;
          next_state = WAIT_EXIT;
        end
      end
      COOL: begin
`ifdef SHOP_COOLDOWN_EN
        if (cool_cnt == 4'd15) next_state = IDLE;
`else
        next_state = IDLE;
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: price latch, timeout counter, result flags, purchase counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      unitCost <= 12'd0;
      wait_cnt <= 3'd0;
      lastOk   <= 1'b0;
      lastFail <= 1'b0;
      buyCount <= 8'd0;
    end else begin
      if (accept) unitCost <= new_cost;

      // ISSUE always precedes WAIT, so clearing here zeroes the count on entry.
      if (state == ISSUE)     wait_cnt <= 3'd0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 3'd1;

      if (succ_evt) begin
        lastOk   <= 1'b1;
        lastFail <= 1'b0;
        if (buyCount != 8'hFF) buyCount <= buyCount + 8'd1;
      end else if (tmo_evt) begin
        lastOk   <= 1'b0;
        lastFail <= 1'b1;
      end
    end
  end

`ifdef SHOP_COOLDOWN_EN
  always_ff @(posedge Clk) begin
    if (Reset)              cool_cnt <= 4'd0;
    else if (state == WAIT) cool_cnt <= 4'd0;
    else if (state == COOL) cool_cnt <= cool_cnt + 4'd1;
  end
`endif

endmodule

// File: doc/shop_purchase_ctrl.md
SHOP_PURCHASE_CTRL -- requirements
Module: shop_purchase_ctrl

Interface
REQ-001 SHALL have Clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have Reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have buyBtn  input  1  single-cycle, already-debounced buy request.
REQ-004 SHALL have itemSel  input  2  item index, sampled only in the cycle buyBtn is accepted.
REQ-005 SHALL have walletLevel  input  2  current wallet level, sampled with itemSel.
REQ-006 SHALL have purchase  output  1  one-cycle purchase strobe to the wallet.
REQ-007 SHALL have unitCost  output  12  cost presented to the wallet; held stable from ISSUE through end of WAIT.
REQ-008 SHALL have buySucc  input  1  wallet success pulse.
REQ-009 SHALL have busy  output  1  high in every state except IDLE.
REQ-010 SHALL have lastOk / lastFail  output  1 each  sticky result of the most recent transaction.
REQ-011 SHALL have buyCount  output  8  count of successful purchases.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, COOL.
REQ-013 IDLE: buyBtn=1 -> latch itemSel/walletLevel, compute unitCost, go to ISSUE next cycle.
REQ-014 Base cost table: item0=10, item1=25, item2=50, item3=100; unitCost = base * (walletLevel+1), 12-bit, max 400, no overflow possible.
REQ-015 ISSUE: purchase=1 for exactly this one cycle; unconditionally go to WAIT.
REQ-016 WAIT: 3-bit timeout counter cleared on entry; buySucc=1 within 8 WAIT cycles -> lastOk=1, lastFail=0, buyCount+1, leave WAIT.
REQ-017 WAIT: 8 cycles without buySucc -> lastOk=0, lastFail=1, leave WAIT; buyCount unchanged.
REQ-018 buySucc in the same cycle as the 8th WAIT cycle SHALL count as success (success has priority over timeout).
REQ-019 buySucc outside WAIT SHALL be ignored.
REQ-020 buyBtn while busy=1 SHALL be dropped, not queued.
REQ-021 buyCount SHALL saturate at 255.
REQ-022 Exit from WAIT goes to COOL or IDLE per REQ-026/027.
REQ-023 purchase SHALL never be asserted in any state but ISSUE.

Reset
REQ-024 Reset=1 SHALL force state IDLE; purchase=0, busy=0, unitCost=0, lastOk=0, lastFail=0, buyCount=0, counters=0, regardless of state.
REQ-025 Reset SHALL override buyBtn and buySucc in the same cycle; a transaction in flight is abandoned with no counter update.

Configuration
REQ-026 SHOP_COOLDOWN_EN defined: after WAIT exit, FSM SHALL spend exactly 16 cycles in COOL (busy=1, buyBtn ignored) then return to IDLE.
REQ-027 SHOP_COOLDOWN_EN undefined: COOL unreachable; WAIT exits directly to IDLE, buyBtn accepted the cycle after exit.

Verification
REQ-028 Reset pulse then idle 5 cycles -> all outputs 0, busy=0.
REQ-029 itemSel=2, walletLevel=1, buyBtn pulse; buySucc 3 cycles after purchase -> unitCost=100, one purchase pulse, lastOk=1, buyCount=1.
REQ-030 itemSel=3, walletLevel=3, no buySucc -> unitCost=400, lastFail=1 after 8 WAIT cycles, buyCount=0.
REQ-031 buyBtn pulsed during WAIT and (cooldown build) during COOL -> no second purchase pulse; with SHOP_COOLDOWN_EN, next buy accepted exactly 16 cycles after WAIT exit.
REQ-032 Reset asserted in WAIT with buySucc same cycle -> IDLE, buyCount unchanged, lastOk=0.
REQ-033 256 successful buys -> buyCount holds 255.
